// File: rtl/jk_ctr_pkg.sv
// -----------------------------------------------------------------------------
// jk_ctr_pkg
//   Shared definitions for the JK-from-D register/counter bank.
//   - mode_e  : operating mode selected by the 2-bit mode input
//   - state_e : sequencing FSM states
// -----------------------------------------------------------------------------
package jk_ctr_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,  // each bit follows its own J/K pair
    MODE_UP     = 2'b01,  // sequenced up-count run
    MODE_DOWN   = 2'b10,  // sequenced down-count run
    MODE_HOLD   = 2'b11   // J=K=0 on every bit
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage : jk_ctr_pkg

// File: rtl/jk_cell_d.sv
// -----------------------------------------------------------------------------
// jk_cell_d
//   One JK flip-flop built from a D flop plus JK excitation logic:
//     D = (J & ~Q) | (~K & Q)
//   JK: 00 hold, 01 clear, 10 set, 11 toggle.
// Ports
//   clk    in  clock, state updates on posedge
//   rst_n  in  synchronous active-low reset, clears Q
//   j_i    in  J input
//   k_i    in  K input
//   q_o    out flop output
// -----------------------------------------------------------------------------
module jk_cell_d (
  input  logic clk,
  input  logic rst_n,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // JK excitation folded into the D input; this is the only place Q is updated.
  assign q_d = (j_i & ~q_q) | (~k_i & q_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : jk_cell_d

// File: rtl/jk_using_d_counter.sv
// -----------------------------------------------------------------------------
// jk_using_d_counter
//   WIDTH-bit bank of JK flops (each a D flop with JK excitation). In direct
//   mode every bit follows its own J/K pair. In up/down mode a start pulse
//   launches a run of len synchronous count steps, after which done pulses
//   for one cycle.
// Ports
//   clk    in   1      clock, all state on posedge
//   reset  in   1      synchronous active-low reset
//   mode   in   2      00 direct, 01 up, 10 down, 11 hold
//   j      in   WIDTH  per-bit J (direct mode)
//   k      in   WIDTH  per-bit K (direct mode)
//   start  in   1      launch a run (modes 01/10, IDLE only)
//   len    in   LEN_W  number of count steps in a run
//   q      out  WIDTH  flop outputs
//   qn     out  WIDTH  ~q
//   busy   out  1      registered, high while in RUN
//   done   out  1      registered, one-cycle pulse after the final step
// -----------------------------------------------------------------------------
module jk_using_d_counter
  import jk_ctr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             busy,
  output logic             done
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  mode_e              mode_q,  mode_d;   // mode latched at run launch
  logic [LEN_W-1:0]   rem_q,   rem_d;    // count steps still to perform in RUN
  logic               busy_q,  done_q;

  mode_e              mode_in;
  logic               direct_en;         // apply external j/k
  logic               count_en;          // apply counter excitation
  logic               count_up;          // direction of the counter excitation
  logic [WIDTH-1:0]   toggle;            // bits that toggle on a count step
  logic [WIDTH-1:0]   j_eff, k_eff;
  logic [WIDTH-1:0]   q_w;

  assign mode_in = mode_e'(mode);

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    direct_en = 1'b0;
    count_en  = 1'b0;
    count_up  = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        unique case (mode_in)
          MODE_DIRECT: direct_en = 1'b1;
          MODE_UP, MODE_DOWN: begin
            // A zero-length request is ignored entirely.
            if (start && (len != '0)) begin
              mode_d   = mode_in;
              count_en = 1'b1;            // first step on the launch edge
              count_up = (mode_in == MODE_UP);
              if (len == LEN_W'(1)) begin
                state_d = S_DONE;
                rem_d   = '0;
              end else begin
                state_d = S_RUN;
                rem_d   = len - LEN_W'(1);
              end
            end
          end
          MODE_HOLD: ;
        endcase
      end

      S_RUN: begin
        // External j/k/mode/start are ignored; direction comes from mode_q.
        count_en = 1'b1;
        count_up = (mode_q == MODE_UP);
        if (rem_q == LEN_W'(1)) begin
          state_d = S_DONE;
          rem_d   = '0;
        end else begin
          rem_d   = rem_q - LEN_W'(1);
        end
      end

      S_DONE: state_d = S_IDLE;       // q held, start not accepted

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter excitation: bit i toggles when all lower bits are 1 (up) or 0
  // (down); bit 0 always toggles. Wrap-around falls out naturally.
  // ---------------------------------------------------------------------------
  always_comb begin
    toggle    = '0;
    toggle[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & (count_up ? q_w[i-1] : ~q_w[i-1]);
    end
  end

  // J/K source select: external pair, counter excitation, or hold.
  always_comb begin
    j_eff = '0;
    k_eff = '0;
    if (direct_en) begin
      j_eff = j;
      k_eff = k;
    end else if (count_en) begin
      j_eff = toggle;
      k_eff = toggle;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous and takes priority over everything, so a run in
  // progress is aborted without producing a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_DIRECT;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Flop bank
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell_d u_cell (
      .clk   (clk),
      .rst_n (reset),
      .j_i   (j_eff[g]),
      .k_i   (k_eff[g]),
      .q_o   (q_w[g])
    );
  end

  assign q    = q_w;
  assign qn   = ~q_w;
  assign busy = busy_q;
  assign done = done_q;

endmodule : jk_using_d_counter

// File: tb/tb_jk_using_d_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_using_d_counter
//   Directed bench for jk_using_d_counter (WIDTH=4, LEN_W=8). Inputs change
//   1 time unit after a rising edge and outputs are sampled at the same point,
//   so every comparison sees the state produced by the preceding edge.
//   Status vector compared per step is {q, busy, done}.
// -----------------------------------------------------------------------------
module tb_jk_using_d_counter;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j, k;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] q, qn;
  logic             busy, done;

  int checks = 0;
  int errors = 0;

  jk_using_d_counter #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .j     (j),
    .k     (k),
    .start (start),
    .len   (len),
    .q     (q),
    .qn    (qn),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] status();
    return {q, busy, done};
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; mode = 2'b00; j = 4'hF; k = 4'hF; start = 1'b0; len = '0;
    tick();
    tick();
    checks++;
    if (status() !== {4'h0, 2'b00}) begin
      errors++; $display("FAIL reset_hold got=%b exp=%b", status(), {4'h0, 2'b00});
    end
    checks++;
    if (qn !== 4'hF) begin
      errors++; $display("FAIL reset_qn got=%h exp=%h", qn, 4'hF);
    end
    reset = 1'b1; mode = 2'b11;
    tick();
    checks++;
    if (status() !== {4'h0, 2'b00}) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", status(), {4'h0, 2'b00});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_direct();
    logic [3:0] jv [4] = '{4'b1010, 4'b0000, 4'hF, 4'h0};
    logic [3:0] kv [4] = '{4'b0000, 4'b0010, 4'hF, 4'h0};
    logic [3:0] ev [4] = '{4'hA,    4'h8,    4'h7, 4'h7};
    mode = 2'b00; start = 1'b1; len = 8'd3;   // start must be ignored here
    for (int i = 0; i < 4; i++) begin
      j = jv[i]; k = kv[i];
      tick();
      checks++;
      if (status() !== {ev[i], 2'b00}) begin
        errors++; $display("FAIL direct_%0d got=%b exp=%b", i, status(), {ev[i], 2'b00});
      end
    end
    checks++;
    if (qn !== 4'h8) begin
      errors++; $display("FAIL direct_qn got=%h exp=%h", qn, 4'h8);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_count_up();
    // From 7: set bits 3..1, clear bit 0 -> E.
    mode = 2'b00; start = 1'b0; j = 4'b1110; k = 4'b0001;
    tick();
    checks++;
    if (q !== 4'hE) begin
      errors++; $display("FAIL up_preload got=%h exp=%h", q, 4'hE);
    end
    mode = 2'b01; start = 1'b1; len = 8'd3; j = 4'h0; k = 4'h0;
    tick();
    checks++;
    if (status() !== {4'hF, 2'b10}) begin
      errors++; $display("FAIL up_step1 got=%b exp=%b", status(), {4'hF, 2'b10});
    end
    start = 1'b0; mode = 2'b11;               // ignored while running
    tick();
    checks++;
    if (status() !== {4'h0, 2'b10}) begin
      errors++; $display("FAIL up_step2_wrap got=%b exp=%b", status(), {4'h0, 2'b10});
    end
    tick();
    checks++;
    if (status() !== {4'h1, 2'b01}) begin
      errors++; $display("FAIL up_step3_done got=%b exp=%b", status(), {4'h1, 2'b01});
    end
    tick();
    checks++;
    if (status() !== {4'h1, 2'b00}) begin
      errors++; $display("FAIL up_after_done got=%b exp=%b", status(), {4'h1, 2'b00});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_count_down();
    mode = 2'b00; j = 4'h0; k = 4'hF;
    tick();
    checks++;
    if (q !== 4'h0) begin
      errors++; $display("FAIL down_preload got=%h exp=%h", q, 4'h0);
    end
    mode = 2'b10; start = 1'b1; len = 8'd2; j = 4'h0; k = 4'h0;
    tick();
    checks++;
    if (status() !== {4'hF, 2'b10}) begin
      errors++; $display("FAIL down_step1_wrap got=%b exp=%b", status(), {4'hF, 2'b10});
    end
    // Disturb mode/start/j/k during RUN: must not affect the count.
    mode = 2'b00; start = 1'b1; j = 4'hF; k = 4'hF;
    tick();
    checks++;
    if (status() !== {4'hE, 2'b01}) begin
      errors++; $display("FAIL down_step2_done got=%b exp=%b", status(), {4'hE, 2'b01});
    end
    mode = 2'b11; start = 1'b0;
    tick();
    checks++;
    if (status() !== {4'hE, 2'b00}) begin
      errors++; $display("FAIL down_after_done got=%b exp=%b", status(), {4'hE, 2'b00});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ignored();
    mode = 2'b01; start = 1'b1; len = 8'd0;
    tick();
    checks++;
    if (status() !== {4'hE, 2'b00}) begin
      errors++; $display("FAIL len0_start got=%b exp=%b", status(), {4'hE, 2'b00});
    end
    start = 1'b0;
    tick();
    checks++;
    if (status() !== {4'hE, 2'b00}) begin
      errors++; $display("FAIL len0_after got=%b exp=%b", status(), {4'hE, 2'b00});
    end
    mode = 2'b11; j = 4'hF; k = 4'hF; start = 1'b1; len = 8'd5;
    tick();
    checks++;
    if (status() !== {4'hE, 2'b00}) begin
      errors++; $display("FAIL hold_mode got=%b exp=%b", status(), {4'hE, 2'b00});
    end
    start = 1'b0; j = 4'h0; k = 4'h0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_abort();
    mode = 2'b00; j = 4'h0; k = 4'hF;
    tick();
    mode = 2'b01; start = 1'b1; len = 8'd10; j = 4'h0; k = 4'h0;
    tick();                                   // step 1 -> 1
    start = 1'b0;
    tick();                                   // step 2 -> 2
    tick();                                   // step 3 -> 3
    tick();                                   // step 4 -> 4
    checks++;
    if (status() !== {4'h4, 2'b10}) begin
      errors++; $display("FAIL abort_mid_run got=%b exp=%b", status(), {4'h4, 2'b10});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (status() !== {4'h0, 2'b00}) begin
      errors++; $display("FAIL abort_reset got=%b exp=%b", status(), {4'h0, 2'b00});
    end
    reset = 1'b1; mode = 2'b11;
    tick();
    checks++;
    if (status() !== {4'h0, 2'b00}) begin
      errors++; $display("FAIL abort_no_done got=%b exp=%b", status(), {4'h0, 2'b00});
    end
    mode = 2'b01; start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0; mode = 2'b11;
    checks++;
    if (status() !== {4'h1, 2'b10}) begin
      errors++; $display("FAIL rerun_step1 got=%b exp=%b", status(), {4'h1, 2'b10});
    end
    tick();
    checks++;
    if (status() !== {4'h2, 2'b01}) begin
      errors++; $display("FAIL rerun_step2 got=%b exp=%b", status(), {4'h2, 2'b01});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    // len=1 goes straight to DONE on the launch edge; start is not taken in DONE.
    tick();                                   // DONE -> IDLE
    mode = 2'b10; start = 1'b1; len = 8'd1;
    tick();
    checks++;
    if (status() !== {4'h1, 2'b01}) begin
      errors++; $display("FAIL len1_done got=%b exp=%b", status(), {4'h1, 2'b01});
    end
    tick();                                   // start held high in DONE
    checks++;
    if (status() !== {4'h1, 2'b00}) begin
      errors++; $display("FAIL done_ignores_start got=%b exp=%b", status(), {4'h1, 2'b00});
    end
    tick();                                   // back in IDLE: start accepted
    checks++;
    if (status() !== {4'h0, 2'b01}) begin
      errors++; $display("FAIL idle_relaunch got=%b exp=%b", status(), {4'h0, 2'b01});
    end
    start = 1'b0; mode = 2'b11;
    tick();
  endtask

  initial begin
    test_reset();
    test_direct();
    test_count_up();
    test_count_down();
    test_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_jk_using_d_counter
